// File: rtl/sobel_pkg.sv
// Shared widths, constants and FSM encoding for the Sobel edge-compute block.
package sobel_pkg;

   localparam int PIX_W   = 8;
   localparam int GRAD_W  = 11;
   localparam int MAG_W   = 11;
   localparam int PIX_MAX = 255;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Gradients stay within +/-1020, so negation never overflows GRAD_W bits.
   function automatic logic [MAG_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
      return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
   endfunction

endpackage

// File: rtl/sobel_gradient.sv
// Stage 1 of the Sobel pipeline: horizontal and vertical gradients of a 3x3 window.
module sobel_gradient
   import sobel_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic [PIX_W-1:0]         d0_i,
   input  logic [PIX_W-1:0]         d1_i,
   input  logic [PIX_W-1:0]         d2_i,
   input  logic [PIX_W-1:0]         d3_i,
   input  logic [PIX_W-1:0]         d5_i,
   input  logic [PIX_W-1:0]         d6_i,
   input  logic [PIX_W-1:0]         d7_i,
   input  logic [PIX_W-1:0]         d8_i,
   output logic                     valid_o,
   output logic signed [GRAD_W-1:0] gx_o,
   output logic signed [GRAD_W-1:0] gy_o
);

   logic [GRAD_W-1:0] gx_pos, gx_neg, gy_pos, gy_neg;

   // Weighted column/row sums are non-negative (max 1020) and fit GRAD_W unsigned.
   always_comb begin
      gx_pos = GRAD_W'(d2_i) + (GRAD_W'(d5_i) << 1) + GRAD_W'(d8_i);
      gx_neg = GRAD_W'(d0_i) + (GRAD_W'(d3_i) << 1) + GRAD_W'(d6_i);
      gy_pos = GRAD_W'(d6_i) + (GRAD_W'(d7_i) << 1) + GRAD_W'(d8_i);
      gy_neg = GRAD_W'(d0_i) + (GRAD_W'(d1_i) << 1) + GRAD_W'(d2_i);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o <= 1'b0;
         gx_o    <= '0;
         gy_o    <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            gx_o <= $signed(gx_pos - gx_neg);
            gy_o <= $signed(gy_pos - gy_neg);
         end
      end
   end

endmodule

// File: rtl/sobel_edge_compute.sv
// Sobel edge compute: 3-stage gradient-magnitude pipeline with per-frame pixel tracking.
// Define SOBEL_BINARY_EN to binarise edge_o against threshold_i instead of saturating.
module sobel_edge_compute
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int OUT_PIXELS = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] d0_i,
   input  logic [PIX_W-1:0] d1_i,
   input  logic [PIX_W-1:0] d2_i,
   input  logic [PIX_W-1:0] d3_i,
   input  logic [PIX_W-1:0] d4_i,
   input  logic [PIX_W-1:0] d5_i,
   input  logic [PIX_W-1:0] d6_i,
   input  logic [PIX_W-1:0] d7_i,
   input  logic [PIX_W-1:0] d8_i,
   input  logic             done_i,
   input  logic [PIX_W-1:0] threshold_i,
   output logic [PIX_W-1:0] edge_o,
   output logic             done_o,
   output logic             frame_done_o,
   output logic             busy_o
);

   localparam int CNT_W = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_PIXELS - 1);

   logic                     v1, v2;
   logic signed [GRAD_W-1:0] gx, gy;
   logic [MAG_W-1:0]         mag;
   logic [PIX_W-1:0]         edge_next;
   logic [CNT_W-1:0]         pix_cnt;
   state_t                   state;

   // The centre pixel carries no weight in either Sobel kernel.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, d4_i};

   sobel_gradient u_gradient (
      .clk     (clk),
      .rst     (rst),
      .valid_i (done_i),
      .d0_i    (d0_i),
      .d1_i    (d1_i),
      .d2_i    (d2_i),
      .d3_i    (d3_i),
      .d5_i    (d5_i),
      .d6_i    (d6_i),
      .d7_i    (d7_i),
      .d8_i    (d8_i),
      .valid_o (v1),
      .gx_o    (gx),
      .gy_o    (gy)
   );

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      edge_next = '0;
`ifdef SOBEL_BINARY_EN
      if (mag >= MAG_W'(threshold_i))
         edge_next = PIX_W'(PIX_MAX);
`else
      if (mag > MAG_W'(PIX_MAX))
         edge_next = PIX_W'(PIX_MAX);
      else
         edge_next = mag[PIX_W-1:0];
`endif
   end

`ifndef SOBEL_BINARY_EN
   logic unused_threshold;
   assign unused_threshold = &{1'b0, threshold_i};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2     <= 1'b0;
         mag    <= '0;
         done_o <= 1'b0;
         edge_o <= '0;
      end else begin
         v2     <= v1;
         done_o <= v2;
         if (v1)
            mag <= grad_abs(gx) + grad_abs(gy);
         if (v2)
            edge_o <= edge_next;
      end
   end

   assign frame_done_o = done_o && (pix_cnt == LAST_CNT);
   assign busy_o       = (state == RUN) || v1 || v2 || done_o;

   // A done_i coinciding with the frame-end pulse already belongs to the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_cnt <= '0;
         state   <= IDLE;
      end else begin
         if (done_o)
            pix_cnt <= frame_done_o ? '0 : pix_cnt + CNT_W'(1);
         case (state)
            IDLE: if (done_i) state <= RUN;
            RUN:  if (frame_done_o && !done_i) state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sobel_edge_compute.md
Name: sobel_edge_compute

Overview:
- Consumer end of the 3x3 window interface: takes windows d0..d8 (row-major, d4 = centre) qualified by a done strobe from the Sobel data buffer.
- Computes the Sobel gradient magnitude and emits one 8-bit edge pixel per window on a 3-stage pipeline.
- Tracks output pixels per frame and pulses a frame-complete strobe for the downstream frame writer.

Parameters:
- IMG_WIDTH, 640, input image width in pixels.
- IMG_HEIGHT, 480, input image height in pixels.
- OUT_PIXELS, (IMG_WIDTH-2)*(IMG_HEIGHT-2), number of windows (edge pixels) per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- d0_i..d8_i  in  8 each  3x3 window pixels, unsigned; d0 = top-left, d8 = bottom-right.
- done_i  in  1  window valid strobe, one window per high cycle.
- threshold_i  in  8  binarisation threshold; used only with the optional feature.
- edge_o  out  8  edge pixel.
- done_o  out  1  edge_o valid strobe.
- frame_done_o  out  1  one-cycle pulse alongside the last done_o of a frame.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - All pipeline valid bits, data registers, counters and outputs go to 0.
  - The FSM goes to IDLE.
  - Windows in flight are discarded and never produce done_o.
- Stage 1, registered when done_i = 1:
  - gx = (d2+2*d5+d8) - (d0+2*d3+d6)
  - gy = (d6+2*d7+d8) - (d0+2*d1+d2)
  - Both signed 11-bit, range -1020..1020. Intermediate sums are zero-extended to 11 bits before subtraction.
- Stage 2: mag = |gx| + |gy|, unsigned 11-bit, range 0..2040.
- Stage 3: edge_o = (mag > 255) ? 255 : mag[7:0] (saturation). done_o asserts with edge_o.
- Latency:
  - done_i high in cycle N gives done_o high in cycle N+3.
  - Full throughput of one window per cycle. No backpressure; the consumer must accept every done_o.
- Valid handling:
  - The valid bit shifts every cycle.
  - Data registers load only when their stage input is valid.
  - edge_o holds its last value while done_o = 0.
- Pixel counter (width clog2(OUT_PIXELS)):
  - Increments on each done_o.
  - When count = OUT_PIXELS-1 and done_o = 1: frame_done_o = 1 for that cycle, and the counter wraps to 0.
- FSM:
  - IDLE -> RUN on the first done_i.
  - RUN -> IDLE on frame_done_o.
  - If done_i = 1 in the same cycle as frame_done_o, the FSM stays in RUN; it has already accepted a new frame.
  - busy_o = (state == RUN) or any pipeline valid bit set.
- Gaps in done_i of any length are legal. Outputs are unaffected except that done_o has matching gaps.

Optional Feature:
- SOBEL_BINARY_EN defined: stage 3 outputs edge_o = (mag >= threshold_i) ? 255 : 0. threshold_i is sampled in stage 3, the same cycle the compare is made.
- Undefined: saturated magnitude output as above; threshold_i is ignored.
- Latency and the done/frame behaviour are identical in both builds.

Decomposition:
- Package sobel_pkg:
  - Constants PIX_W=8, GRAD_W=11, MAG_W=11, PIX_MAX=255.
  - FSM state enum {IDLE, RUN}.
- One sub-module, sobel_gradient: stage-1 gx/gy arithmetic plus its registers, with valid in and valid out. Stages 2-3, the counter and the FSM stay in the top level.

Test Plan:
- Uniform window, all nine pixels = 100, done_i pulse at cycle 10 -> done_o at cycle 13 with edge_o = 0.
- Vertical edge d0=d3=d6=0, d2=d5=d8=255 -> gx=1020, gy=0, edge_o = 255 (saturated).
- d2=10, all others 0 -> gx=10, gy=-10, mag=20, edge_o = 20.
  - With SOBEL_BINARY_EN and threshold_i=15 -> edge_o = 255.
  - With threshold_i=21 -> edge_o = 0.
- IMG_WIDTH=5, IMG_HEIGHT=4 (OUT_PIXELS=6), 12 back-to-back windows -> frame_done_o pulses with the 6th and 12th done_o; busy_o drops 1 cycle after the 12th.
- done_i pattern 1,0,0,1,1,0,1 -> done_o repeats the pattern 3 cycles later; edge_o stable during the low cycles.
- rst driven low for 1 cycle while 2 windows are in the pipeline mid-frame -> no done_o for them; the next 6 windows yield frame_done_o on the 6th.
